// File: rtl/multi_output_channel_buffer.sv
// multi_output_channel_buffer: NUM_CHANNELS independent per-link output FIFOs
// with req/ack toward the router links, almost_full, sticky overflow, flush.
// Optional zero-latency bypass on an empty channel: OUTPUT_CHANNEL_BUFFER_BYPASS_EN.

// One output channel: FIFO storage, pointers, occupancy and overflow flag.
module multi_output_channel_buffer_ch #(
   parameter int PACKET_WIDTH          = 64,
   parameter int FIFO_DEPTH            = 4,
   parameter int ALMOST_FULL_THRESHOLD = 3,
   parameter int CW                    = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    flush,
   input  logic                    enqueue,
   input  logic [PACKET_WIDTH-1:0] enqueue_packet,
   output logic                    full,
   output logic                    almost_full,
   output logic [CW-1:0]           count,
   output logic                    overflow,
   input  logic                    overflow_clear,
   output logic                    link_req,
   output logic [PACKET_WIDTH-1:0] link_packet,
   input  logic                    link_ack
);
   localparam int PTRW = $clog2(FIFO_DEPTH);

   logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTRW-1:0]         head, tail;
   logic                    is_empty, act, deq, wr, rd, drop, byp_take;

   assign is_empty    = (count == '0);
   assign full        = (count == CW'(FIFO_DEPTH));
   assign almost_full = (count >= CW'(ALMOST_FULL_THRESHOLD));
   assign act         = enable && !flush;

`ifdef OUTPUT_CHANNEL_BUFFER_BYPASS_EN
   logic byp;
   // empty channel forwards the incoming packet straight to the link
   assign byp         = act && is_empty && enqueue;
   assign link_req    = enable && (!is_empty || byp);
   assign link_packet = byp ? enqueue_packet : mem[head];
   assign byp_take    = byp && link_ack;
`else
   assign link_req    = enable && !is_empty;
   assign link_packet = mem[head];
   assign byp_take    = 1'b0;
`endif

   assign deq  = link_ack && link_req;
   // a full channel still accepts when the head leaves in the same cycle
   assign wr   = act && enqueue && (!full || deq) && !byp_take;
   assign rd   = act && deq && !is_empty;
   assign drop = act && enqueue && full && !deq;

   function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
      return (p == PTRW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // pointers and occupancy; flush wins over everything but reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (wr) tail <= ptr_inc(tail);
         if (rd) head <= ptr_inc(head);
         if (wr && !rd)      count <= count + 1'b1;
         else if (rd && !wr) count <= count - 1'b1;
      end
   end

   // packet storage, deliberately not reset
   always_ff @(posedge clock) begin
      if (wr) mem[tail] <= enqueue_packet;
   end

   // sticky overflow; a new drop beats a clear in the same cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)              overflow <= 1'b0;
      else if (drop)           overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
   end
endmodule

module multi_output_channel_buffer #(
   parameter int NUM_CHANNELS          = 4,
   parameter int PACKET_WIDTH          = 64,
   parameter int FIFO_DEPTH            = 4,
   parameter int ALMOST_FULL_THRESHOLD = 3,
   localparam int CW                   = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic                                 flush,
   input  logic [NUM_CHANNELS-1:0]              enqueue,
   input  logic [NUM_CHANNELS*PACKET_WIDTH-1:0] enqueue_packet,
   output logic [NUM_CHANNELS-1:0]              full,
   output logic [NUM_CHANNELS-1:0]              almost_full,
   output logic [NUM_CHANNELS*CW-1:0]           count,
   output logic [NUM_CHANNELS-1:0]              overflow,
   input  logic [NUM_CHANNELS-1:0]              overflow_clear,
   output logic [NUM_CHANNELS-1:0]              link_req,
   output logic [NUM_CHANNELS*PACKET_WIDTH-1:0] link_packet,
   input  logic [NUM_CHANNELS-1:0]              link_ack,
   output logic                                 quiescent
);
   logic [NUM_CHANNELS-1:0] busy;

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      multi_output_channel_buffer_ch #(
         .PACKET_WIDTH(PACKET_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
         .ALMOST_FULL_THRESHOLD(ALMOST_FULL_THRESHOLD), .CW(CW)
      ) u_ch (
         .clock(clock), .reset(reset), .enable(enable), .flush(flush),
         .enqueue(enqueue[g]),
         .enqueue_packet(enqueue_packet[g*PACKET_WIDTH +: PACKET_WIDTH]),
         .full(full[g]), .almost_full(almost_full[g]),
         .count(count[g*CW +: CW]),
         .overflow(overflow[g]), .overflow_clear(overflow_clear[g]),
         .link_req(link_req[g]),
         .link_packet(link_packet[g*PACKET_WIDTH +: PACKET_WIDTH]),
         .link_ack(link_ack[g])
      );
      assign busy[g] = (count[g*CW +: CW] != '0);
   end

   assign quiescent = ~|busy;
endmodule

// File: tb/tb_multi_output_channel_buffer.sv
// Bench for multi_output_channel_buffer: two instances (depth 4 and depth 3)
// checked every cycle against per-channel packet queues.
module tb_multi_output_channel_buffer;
`ifdef OUTPUT_CHANNEL_BUFFER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clock = 1'b0, reset = 1'b0, enable = 1'b0, flush = 1'b0;
   logic [3:0]   enq [2], ack [2], oclr [2];
   logic [255:0] pkt [2];
   logic [3:0]   full [2], af [2], ovf [2], lreq [2];
   logic [255:0] lpkt [2];
   logic [11:0]  cnt [2];
   logic         quie [2];

   logic [63:0]  mq [8][$];
   bit           m_ovf [8];
   int           n_chk = 0, n_fail = 0;

   always #5 clock = ~clock;

   multi_output_channel_buffer u_d4 (
      .clock(clock), .reset(reset), .enable(enable), .flush(flush),
      .enqueue(enq[0]), .enqueue_packet(pkt[0]), .full(full[0]),
      .almost_full(af[0]), .count(cnt[0]), .overflow(ovf[0]),
      .overflow_clear(oclr[0]), .link_req(lreq[0]), .link_packet(lpkt[0]),
      .link_ack(ack[0]), .quiescent(quie[0]));

   multi_output_channel_buffer #(.FIFO_DEPTH(3), .ALMOST_FULL_THRESHOLD(2)) u_d3 (
      .clock(clock), .reset(reset), .enable(enable), .flush(flush),
      .enqueue(enq[1]), .enqueue_packet(pkt[1]), .full(full[1]),
      .almost_full(af[1]), .count(cnt[1]), .overflow(ovf[1]),
      .overflow_clear(oclr[1]), .link_req(lreq[1]), .link_packet(lpkt[1]),
      .link_ack(ack[1]), .quiescent(quie[1]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         int d = (k == 0) ? 4 : 3;
         int t = (k == 0) ? 3 : 2;
         bit allz = 1'b1;
         for (int i = 0; i < 4; i++) begin
            int  idx = k*4 + i;
            int  sz  = mq[idx].size();
            bit  byp = BYP && enable && !flush && (sz == 0) && enq[k][i];
            bit  req = enable && ((sz != 0) || byp);
            string p = $sformatf("d%0d.ch%0d.", k, i);
            if (sz != 0) allz = 1'b0;
            chk({p, "count"},  64'(cnt[k][i*3 +: 3]), 64'(sz));
            chk({p, "full"},   64'(full[k][i]), 64'(sz == d));
            chk({p, "afull"},  64'(af[k][i]),   64'(sz >= t));
            chk({p, "ovf"},    64'(ovf[k][i]),  64'(m_ovf[idx]));
            chk({p, "req"},    64'(lreq[k][i]), 64'(req));
            if (req) chk({p, "pkt"}, lpkt[k][i*64 +: 64],
                         byp ? pkt[k][i*64 +: 64] : mq[idx][0]);
         end
         chk($sformatf("d%0d.quiescent", k), 64'(quie[k]), 64'(allz));
      end
   endtask

   // queue-level view of one clock edge
   task automatic model_edge();
      if (!reset) return;
      for (int k = 0; k < 2; k++) begin
         int d = (k == 0) ? 4 : 3;
         for (int i = 0; i < 4; i++) begin
            int idx = k*4 + i;
            int sz  = mq[idx].size();
            bit e   = enq[k][i];
            bit a   = ack[k][i];
            bit setov = 1'b0;
            if (flush) mq[idx].delete();
            else if (enable) begin
               bit byp = BYP && (sz == 0) && e;
               bit deq = a && ((sz != 0) || byp);
               if (byp && a) begin end
               else if (e && (sz < d || deq)) begin
                  if (deq) void'(mq[idx].pop_front());
                  mq[idx].push_back(pkt[k][i*64 +: 64]);
               end
               else if (e) setov = 1'b1;
               else if (deq) void'(mq[idx].pop_front());
            end
            if (setov) m_ovf[idx] = 1'b1;
            else if (oclr[k][i]) m_ovf[idx] = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < 8; j++) begin
         mq[j].delete();
         m_ovf[j] = 1'b0;
      end
   endtask

   task automatic idle();
      for (int k = 0; k < 2; k++) begin
         enq[k] = '0; ack[k] = '0; oclr[k] = '0;
      end
      flush = 1'b0;
   endtask

   // inputs already driven after a negedge; check, clock, update model
   task automatic cyc();
      #1 check_all();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   initial begin
      idle();
      pkt[0] = '0; pkt[1] = '0;
      model_reset();
      #3 check_all();
      @(negedge clock);
      reset = 1'b1; enable = 1'b1;
      cyc();

      // ch0 fill to full, fifth enqueue dropped, then clear overflow
      for (int n = 0; n < 5; n++) begin
         enq[0][0] = 1'b1; pkt[0][63:0] = 64'hA0 + 64'(n); cyc();
      end
      idle(); cyc();
      oclr[0][0] = 1'b1; cyc();
      idle(); cyc();

      // ch1 full, enqueue E while the head is acked, then drain both
      for (int n = 0; n < 4; n++) begin
         enq[0][1] = 1'b1; pkt[0][127:64] = 64'hB0 + 64'(n); cyc();
      end
      enq[0][1] = 1'b1; ack[0][1] = 1'b1; pkt[0][127:64] = 64'hEEEE; cyc();
      idle(); ack[0] = 4'b0011;
      for (int n = 0; n < 5; n++) cyc();

      // depth-3 instance: ten enqueue/ack pairs on ch2, pointers wrap
      for (int n = 0; n < 10; n++) begin
         idle(); enq[1][2] = 1'b1; ack[1][2] = 1'b1; pkt[1][191:128] = 64'(n); cyc();
      end
      idle(); ack[1][2] = 1'b1; cyc();
      // depth-3 full and overflow on ch0
      for (int n = 0; n < 4; n++) begin
         idle(); enq[1][0] = 1'b1; pkt[1][63:0] = 64'hC0 + 64'(n); cyc();
      end

      // flush with concurrent enqueues; overflow flags stay
      idle(); enq[0] = 4'b1001; pkt[0] = {64'hD3, 128'h0, 64'hD0}; cyc(); cyc();
      flush = 1'b1; cyc();
      idle(); cyc();

      // empty ch0 enqueue with ack the same cycle
      enq[0][0] = 1'b1; ack[0][0] = 1'b1; pkt[0][63:0] = 64'h5A5A; cyc();
      idle(); cyc();
      ack[0][0] = 1'b1; cyc(); cyc();

      // enable low: enqueues ignored, no overflow, link_req low
      idle(); enable = 1'b0; enq[0] = 4'hF; enq[1] = 4'hF; ack[1] = 4'hF; cyc(); cyc();
      oclr[1] = 4'hF; cyc();
      enable = 1'b1; idle(); cyc();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         enable = ($urandom_range(0, 9) != 0);
         flush  = ($urandom_range(0, 39) == 0);
         for (int k = 0; k < 2; k++) begin
            enq[k]  = 4'($urandom);
            ack[k]  = 4'($urandom) & 4'($urandom | $urandom);
            oclr[k] = 4'($urandom) & 4'($urandom) & 4'($urandom);
            pkt[k]  = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
         end
         cyc();
      end

      // reset mid-run with three packets queued on ch2
      idle(); enable = 1'b1; flush = 1'b1; cyc();
      idle();
      for (int n = 0; n < 3; n++) begin
         enq[0][2] = 1'b1; pkt[0][191:128] = 64'hF0 + 64'(n); cyc();
      end
      idle();
      #2 reset = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clock);
      reset = 1'b1;
      for (int n = 0; n < 3; n++) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
